// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter phase monitor.
// Holds the monitor FSM states and the Johnson pattern generator.
package johnson_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } jstate_e;

    localparam int JC_WIDTH = 4;
    localparam int NPHASE   = 2 * JC_WIDTH;
    localparam int IDX_W    = $clog2(NPHASE);

    // Pattern idx fills ones from bit 0 upward, then drains them from bit 0 upward.
    function automatic logic [31:0] jc_pattern(input int idx, input int width = JC_WIDTH);
        logic [31:0] pat;
        pat = 32'd0;
        for (int i = 0; i < 32; i++) begin
            pat[i] = (i < width) && (idx > i) && (idx <= i + width);
        end
        return pat;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decoder: maps a Johnson counter pattern to {valid, idx}.
// Illegal patterns return valid = 0 and idx = 0.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int IDX_W_P = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0]   pat,
    output logic               valid,
    output logic [IDX_W_P-1:0] idx
);

    localparam int NPH = 2 * WIDTH;

    logic [31:0] pat_ref_s;
    logic        hit_s;

    // Compare against every legal pattern; at most one can match.
    always_comb begin
        valid     = 1'b0;
        idx       = {IDX_W_P{1'b0}};
        pat_ref_s = 32'd0;
        hit_s     = 1'b0;
        for (int k = 0; k < NPH; k++) begin
            pat_ref_s = jc_pattern(k, WIDTH);
            hit_s     = (pat == pat_ref_s[WIDTH-1:0]);
            valid     = valid | hit_s;
            idx       = hit_s ? IDX_W_P'(k) : idx;
        end
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: two register stages, legality/lock FSM,
// sticky error with saturating count, and revolution counting while locked.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int REV_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [WIDTH-1:0]              jc_q,
    input  logic                          clear_err,
    output logic [2*WIDTH-1:0]            phase,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          locked,
    output logic                          err,
    output logic [7:0]                    err_count,
    output logic [REV_W-1:0]              rev_count,
    output logic                          rev_pulse
);

    localparam int NPH   = 2 * WIDTH;
    localparam int IW    = $clog2(NPH);
    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NPH - 1);

    logic [WIDTH-1:0] cur_r;
    logic [WIDTH-1:0] prev_r;
    logic             clr_r;

    logic             cur_valid_s;
    logic [IW-1:0]    cur_idx_s;
    logic             prev_valid_s;
    logic [IW-1:0]    prev_idx_s;

    jstate_e          state_r;
    jstate_e          state_next_s;
    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] run_next_s;
    logic [RUN_W-1:0] run_inc_s;
    logic [IW-1:0]    succ_idx_s;
    logic             is_hold_s;
    logic             is_step_s;
    logic             err_event_s;
    logic             rev_hit_s;
    logic [NPH-1:0]   phase_oh_s;

    johnson_decode #(.WIDTH(WIDTH), .IDX_W_P(IW)) u_dec_cur (
        .pat   (cur_r),
        .valid (cur_valid_s),
        .idx   (cur_idx_s)
    );

    johnson_decode #(.WIDTH(WIDTH), .IDX_W_P(IW)) u_dec_prev (
        .pat   (prev_r),
        .valid (prev_valid_s),
        .idx   (prev_idx_s)
    );

    // Stage 1: clear_err travels with jc_q so both are judged on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_r  <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
            clr_r  <= 1'b0;
        end else begin
            cur_r  <= jc_q;
            prev_r <= cur_r;
            clr_r  <= clear_err;
        end
    end

    // Transition classification between the two registered samples.
    always_comb begin
        succ_idx_s = (prev_idx_s == LAST_IDX) ? {IW{1'b0}} : (prev_idx_s + {{(IW-1){1'b0}}, 1'b1});
        is_hold_s  = cur_valid_s && (cur_r == prev_r);
        is_step_s  = cur_valid_s && prev_valid_s && !is_hold_s && (cur_idx_s == succ_idx_s);
        run_inc_s  = run_r + 4'd1;
        phase_oh_s = {{(NPH-1){1'b0}}, 1'b1} << cur_idx_s;
    end

    // Next-state logic; illegal patterns dominate, anything unclassified is a restart or jump.
    always_comb begin
        state_next_s = state_r;
        run_next_s   = run_r;
        err_event_s  = 1'b0;
        rev_hit_s    = 1'b0;
        if (!cur_valid_s) begin
            err_event_s  = 1'b1;
            state_next_s = SEARCH;
            run_next_s   = {RUN_W{1'b0}};
        end else if (is_hold_s) begin
            state_next_s = state_r;
        end else if (is_step_s) begin
            case (state_r)
                SEARCH: begin
                    run_next_s   = run_inc_s;
                    state_next_s = (run_inc_s == LOCK_RUN) ? LOCKED : SEARCH;
                end
                LOCKED: begin
                    rev_hit_s = (prev_idx_s == LAST_IDX);
                end
                default: begin
                    state_next_s = SEARCH;
                    run_next_s   = {RUN_W{1'b0}};
                end
            endcase
        end else begin
            // Landing on idx 0 is a restart and never an error; a locked jump is.
            err_event_s  = (state_r == LOCKED) && prev_valid_s && (cur_idx_s != {IW{1'b0}});
            state_next_s = SEARCH;
            run_next_s   = {RUN_W{1'b0}};
        end
    end

    // FSM state, run length and the registered lock indication.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= SEARCH;
            run_r   <= {RUN_W{1'b0}};
            locked  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            run_r   <= run_next_s;
            locked  <= (state_next_s == LOCKED);
        end
    end

    // Phase decode outputs; phase_idx keeps its last legal value on illegal input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= {NPH{1'b0}};
            phase_idx <= {IW{1'b0}};
        end else if (cur_valid_s) begin
            phase     <= phase_oh_s;
            phase_idx <= cur_idx_s;
        end else begin
            phase     <= {NPH{1'b0}};
            phase_idx <= phase_idx;
        end
    end

    // Sticky error and saturating count; a new error outranks a simultaneous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else if (err_event_s) begin
            err       <= 1'b1;
            err_count <= clr_r ? 8'd1 : ((err_count == 8'd255) ? 8'd255 : (err_count + 8'd1));
        end else if (clr_r) begin
            err       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err       <= err;
            err_count <= err_count;
        end
    end

    // Revolution counter and strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rev_count <= {REV_W{1'b0}};
            rev_pulse <= 1'b0;
        end else begin
            rev_pulse <= rev_hit_s;
            rev_count <= rev_hit_s ? (rev_count + {{(REV_W-1){1'b0}}, 1'b1}) : rev_count;
        end
    end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed scoreboard bench for johnson_phase_monitor (WIDTH=4, LOCK_COUNT=4).
module tb_johnson_phase_monitor;

    localparam int LOCK = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  jc_q;
    logic        clear_err;
    logic [7:0]  phase;
    logic [2:0]  phase_idx;
    logic        locked;
    logic        err;
    logic [7:0]  err_count;
    logic [15:0] rev_count;
    logic        rev_pulse;

    always #5 clock = ~clock;

    johnson_phase_monitor #(.WIDTH(4), .LOCK_COUNT(LOCK), .REV_W(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .jc_q      (jc_q),
        .clear_err (clear_err),
        .phase     (phase),
        .phase_idx (phase_idx),
        .locked    (locked),
        .err       (err),
        .err_count (err_count),
        .rev_count (rev_count),
        .rev_pulse (rev_pulse)
    );

    typedef struct {
        logic [7:0]  phase;
        logic [2:0]  idx;
        logic        locked;
        logic        err;
        logic [7:0]  cnt;
        logic [15:0] rev;
        logic        pulse;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         rev_seen = 0;
    int         pos = 0;
    logic [3:0] legal_tbl [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [3:0] illegal_tbl [4] = '{4'b0101, 4'b1010, 4'b0100, 4'b1001};

    logic [3:0]  m_prev;
    bit          m_locked;
    int          m_run;
    logic        m_err;
    int          m_cnt;
    logic [15:0] m_rev;
    logic [7:0]  m_phase;
    logic [2:0]  m_idx;

    function automatic int idx_of(input logic [3:0] p);
        for (int i = 0; i < 8; i++) begin
            if (legal_tbl[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = 4'b0000; m_locked = 1'b0; m_run = 0; m_err = 1'b0;
        m_cnt = 0; m_rev = 16'd0; m_phase = 8'd0; m_idx = 3'd0;
    endtask

    // Expected outputs for the edge that judges pat against the previous pattern.
    task automatic model_push(input logic [3:0] pat, input logic clr);
        exp_t e;
        int ci;
        int pi;
        bit ev;
        bit rev;
        ci = idx_of(pat);
        pi = idx_of(m_prev);
        ev = 1'b0;
        rev = 1'b0;
        if (ci < 0) begin
            ev = 1'b1; m_locked = 1'b0; m_run = 0;
        end else if (pat == m_prev) begin
            m_run = m_run;
        end else if (pi >= 0 && ci == (pi + 1) % 8) begin
            if (m_locked) begin
                rev = (pi == 7);
            end else begin
                m_run++;
                if (m_run == LOCK) m_locked = 1'b1;
            end
        end else begin
            if (m_locked && ci != 0) ev = 1'b1;
            m_locked = 1'b0; m_run = 0;
        end
        if (ev) begin
            m_err = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        end else if (clr) begin
            m_err = 1'b0; m_cnt = 0;
        end
        if (rev) m_rev = m_rev + 16'd1;
        if (ci >= 0) begin
            m_phase = 8'd1 << ci; m_idx = 3'(ci);
        end else begin
            m_phase = 8'd0;
        end
        e.phase = m_phase; e.idx = m_idx; e.locked = m_locked; e.err = m_err;
        e.cnt = 8'(m_cnt); e.rev = m_rev; e.pulse = rev;
        sb_q.push_back(e);
        m_prev = pat;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        total++;
        assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_phase",     32'(phase),     32'(e.phase));
            check("sb_phase_idx", 32'(phase_idx), 32'(e.idx));
            check("sb_locked",    32'(locked),    32'(e.locked));
            check("sb_err",       32'(err),       32'(e.err));
            check("sb_err_count", 32'(err_count), 32'(e.cnt));
            check("sb_rev_count", 32'(rev_count), 32'(e.rev));
            check("sb_rev_pulse", 32'(rev_pulse), 32'(e.pulse));
        end
        if (rev_pulse === 1'b1) rev_seen++;
    endtask

    task automatic tick(input logic [3:0] pat, input logic clr);
        jc_q = pat;
        clear_err = clr;
        model_push(pat, clr);
        @(posedge clock);
        #1;
        pop_check();
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            pos = (pos + 1) % 8;
            tick(legal_tbl[pos], 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},     32'(phase),     32'd0);
        check({tag, "_phase_idx"}, 32'(phase_idx), 32'd0);
        check({tag, "_locked"},    32'(locked),    32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_rev_count"}, 32'(rev_count), 32'd0);
        check({tag, "_rev_pulse"}, 32'(rev_pulse), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; jc_q = 4'b0000; clear_err = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        reset_n = 1'b1;
        model_push(4'b0000, 1'b0);

        // Lock-up: hold 0000, then four steps to 1111.
        pos = 0;
        for (int i = 0; i < 3; i++) tick(4'b0000, 1'b0);
        check("hold_locked", 32'(locked), 32'd0);
        adv(4);
        tick(legal_tbl[pos], 1'b0);
        check("lock_locked",    32'(locked),    32'd1);
        check("lock_phase",     32'(phase),     32'h10);
        check("lock_phase_idx", 32'(phase_idx), 32'd4);
        check("lock_err",       32'(err),       32'd0);

        // Two full revolutions.
        rev_seen = 0;
        adv(12);
        tick(legal_tbl[pos], 1'b0);
        check("rev_pulses", 32'(rev_seen),  32'd2);
        check("rev_count",  32'(rev_count), 32'd2);

        // Illegal pattern, resume, relock after four steps.
        adv(2);
        tick(4'b0101, 1'b0);
        pos = 3;
        tick(legal_tbl[pos], 1'b0);
        check("ill_err",       32'(err),       32'd1);
        check("ill_err_count", 32'(err_count), 32'd1);
        check("ill_locked",    32'(locked),    32'd0);
        check("ill_phase",     32'(phase),     32'd0);
        adv(4);
        check("ill_relock_early", 32'(locked), 32'd0);
        tick(legal_tbl[pos], 1'b0);
        check("ill_relock", 32'(locked), 32'd1);

        // Jump while locked, then clear.
        adv(3);
        pos = 4;
        tick(legal_tbl[pos], 1'b0);
        tick(legal_tbl[pos], 1'b0);
        check("jump_err_count", 32'(err_count), 32'd2);
        check("jump_locked",    32'(locked),    32'd0);
        tick(legal_tbl[pos], 1'b1);
        tick(legal_tbl[pos], 1'b0);
        check("clear_err",       32'(err),       32'd0);
        check("clear_err_count", 32'(err_count), 32'd0);

        // Restart from 0111 to 0000.
        adv(4);
        adv(3);
        check("restart_pre_locked", 32'(locked), 32'd1);
        pos = 0;
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        check("restart_locked", 32'(locked), 32'd0);
        check("restart_err",    32'(err),    32'd0);

        // Error and clear_err on the same edge.
        for (int i = 0; i < 3; i++) tick(4'b0101, 1'b0);
        tick(4'b1001, 1'b1);
        check("simul_pre_count", 32'(err_count), 32'd3);
        tick(4'b0000, 1'b0);
        check("simul_err",       32'(err),       32'd1);
        check("simul_err_count", 32'(err_count), 32'd1);

        // Saturation.
        for (int i = 0; i < 300; i++) tick(illegal_tbl[i % 4], 1'b0);
        tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b0);
        check("sat_err_count", 32'(err_count), 32'd255);

        // Mid-revolution asynchronous reset.
        pos = 0;
        adv(5);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        sb_q.delete();
        model_reset();
        jc_q = 4'b0000;
        #1;
        reset_n = 1'b1;
        model_push(4'b0000, 1'b0);
        pos = 0;
        adv(4);
        tick(legal_tbl[pos], 1'b0);
        check("post_rst_locked", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
